// File: rtl/ann_pkg.sv
// Shared types and default dimensions for the ANN leaf-search pipeline.
package ann_pkg;

   localparam int ANN_PATCH_WIDTH     = 55;
   localparam int ANN_ADDRESS_WIDTH   = 8;
   localparam int ANN_LEAF_SIZE       = 8;
   localparam int ANN_LEAF_ADDR_WIDTH = ANN_ADDRESS_WIDTH + $clog2(ANN_LEAF_SIZE);

   // Query as handed over by internal_node_tree
   typedef struct packed {
      logic [ANN_ADDRESS_WIDTH-1:0] leaf_index;
      logic [ANN_PATCH_WIDTH-1:0]   patch;
   } query_t;

   // One candidate beat towards the distance/compare stage
   typedef struct packed {
      logic [ANN_PATCH_WIDTH-1:0]     query;
      logic [ANN_PATCH_WIDTH-1:0]     cand;
      logic [ANN_LEAF_ADDR_WIDTH-1:0] idx;
      logic                           last;
   } cand_t;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO used as the query queue.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             wrst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNTW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTRW-1:0]  wptr;
   logic [PTRW-1:0]  rptr;
   logic [CNTW-1:0]  count;
   logic             push;
   logic             pop;

   assign full    = (count == CNTW'(DEPTH));
   assign empty   = (count == '0);
   assign push    = wr_en && !full;
   assign pop     = rd_en && !empty;
   assign rd_data = mem[rptr];

   // Storage array, no reset needed on the payload
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= wr_data;
      end
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (!wrst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wptr <= (wptr == PTRW'(DEPTH - 1)) ? '0 : wptr + PTRW'(1);
         end
         if (pop) begin
            rptr <= (rptr == PTRW'(DEPTH - 1)) ? '0 : rptr + PTRW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNTW'(1);
            2'b01:   count <= count - CNTW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/leaf_candidate_fetch.sv
// Streams every stored patch of a query's leaf out of the leaf SRAM,
// pairing each candidate with its query for the distance stage.
module leaf_candidate_fetch
   import ann_pkg::*;
#(
   parameter int  PATCH_WIDTH     = ANN_PATCH_WIDTH,
   parameter int  ADDRESS_WIDTH   = ANN_ADDRESS_WIDTH,
   parameter int  LEAF_SIZE       = ANN_LEAF_SIZE,
   parameter int  QDEPTH          = 4,
   localparam int LEAF_ADDR_WIDTH = ADDRESS_WIDTH + $clog2(LEAF_SIZE)
) (
   input  logic                       clk,
   input  logic                       wrst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ADDRESS_WIDTH-1:0]   in_leaf_index,
   input  logic [PATCH_WIDTH-1:0]     in_patch,
   output logic                       mem_ren,
   output logic [LEAF_ADDR_WIDTH-1:0] mem_radr,
   input  logic [PATCH_WIDTH-1:0]     mem_rdata,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [PATCH_WIDTH-1:0]     out_query,
   output logic [PATCH_WIDTH-1:0]     out_cand,
   output logic [LEAF_ADDR_WIDTH-1:0] out_cand_idx,
   output logic                       out_last,
   output logic                       busy
);

   localparam int KW = $clog2(LEAF_SIZE);

   typedef struct packed {
      logic [ADDRESS_WIDTH-1:0] leaf_index;
      logic [PATCH_WIDTH-1:0]   patch;
   } entry_t;

   typedef struct packed {
      logic [PATCH_WIDTH-1:0]     query;
      logic [PATCH_WIDTH-1:0]     cand;
      logic [LEAF_ADDR_WIDTH-1:0] idx;
      logic                       last;
   } beat_t;

   entry_t                     fifo_wdata;
   entry_t                     fifo_head;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic                       fifo_push;
   logic                       fifo_pop;

   fetch_state_t               state;
   logic [KW-1:0]              k;
   logic [ADDRESS_WIDTH-1:0]   cur_leaf;
   logic [PATCH_WIDTH-1:0]     cur_patch;

   logic                       inflight;
   logic [PATCH_WIDTH-1:0]     rd_query;
   logic [LEAF_ADDR_WIDTH-1:0] rd_idx;
   logic                       rd_last;

   beat_t                      ob0;
   beat_t                      ob1;
   beat_t                      cap_beat;
   logic [1:0]                 occ;
   logic                       out_pop;
   logic [2:0]                 credit;
   logic                       issue;
   logic                       leaf_end;

   assign in_ready   = wrst_n && !fifo_full;
   assign fifo_push  = in_valid && in_ready;
   assign fifo_wdata = '{leaf_index: in_leaf_index, patch: in_patch};

   sync_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (QDEPTH)
   ) u_qfifo (
      .clk     (clk),
      .wrst_n  (wrst_n),
      .wr_en   (fifo_push),
      .wr_data (fifo_wdata),
      .rd_en   (fifo_pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // The head popping this cycle frees its slot, so it is credited back;
   // without that the buffer would throttle to one beat every other cycle.
   assign out_pop  = (occ != 2'd0) && out_ready;
   assign credit   = 3'(occ) - 3'(out_pop) + 3'(inflight);
   assign issue    = (state == ST_ISSUE) && (credit < 3'd2);
   assign leaf_end = (k == '1);
   assign fifo_pop = !fifo_empty && ((state == ST_IDLE) || (issue && leaf_end));

   assign mem_ren  = issue;
   assign mem_radr = {cur_leaf, k};

   // Query sequencing: load a query, walk k across the leaf, chain the next query
   always_ff @(posedge clk) begin
      if (!wrst_n) begin
         state     <= ST_IDLE;
         k         <= '0;
         cur_leaf  <= '0;
         cur_patch <= '0;
      end else if (fifo_pop) begin
         state     <= ST_ISSUE;
         k         <= '0;
         cur_leaf  <= fifo_head.leaf_index;
         cur_patch <= fifo_head.patch;
      end else if (issue) begin
         if (leaf_end) begin
            state <= ST_IDLE;
            k     <= '0;
         end else begin
            k <= k + KW'(1);
         end
      end
   end

   // Side-band fields that travel alongside an outstanding SRAM read
   always_ff @(posedge clk) begin
      if (!wrst_n) begin
         inflight <= 1'b0;
         rd_query <= '0;
         rd_idx   <= '0;
         rd_last  <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            rd_query <= cur_patch;
            rd_idx   <= mem_radr;
            rd_last  <= leaf_end;
         end
      end
   end

   assign cap_beat = '{query: rd_query, cand: mem_rdata, idx: rd_idx, last: rd_last};

   // Two-entry output buffer, ob0 is always the head
   always_ff @(posedge clk) begin
      if (!wrst_n) begin
         ob0 <= '0;
         ob1 <= '0;
         occ <= '0;
      end else begin
         case ({out_pop, inflight})
            2'b01: begin
               if (occ == 2'd0) begin
                  ob0 <= cap_beat;
               end else begin
                  ob1 <= cap_beat;
               end
               occ <= occ + 2'd1;
            end
            2'b10: begin
               ob0 <= ob1;
               occ <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  ob0 <= cap_beat;
               end else begin
                  ob0 <= ob1;
                  ob1 <= cap_beat;
               end
            end
            default: begin
               occ <= occ;
            end
         endcase
      end
   end

   assign out_valid    = (occ != 2'd0);
   assign out_query    = ob0.query;
   assign out_cand     = ob0.cand;
   assign out_cand_idx = ob0.idx;
   assign out_last     = ob0.last;

   assign busy = !fifo_empty || (state == ST_ISSUE) || inflight || (occ != 2'd0);

endmodule

// File: tb/tb_leaf_candidate_fetch.sv
// Self-checking bench for leaf_candidate_fetch with a 1-cycle leaf SRAM model.
module tb_leaf_candidate_fetch;

   localparam int PW  = 55;
   localparam int AW  = 8;
   localparam int LS  = 8;
   localparam int LAW = AW + 3;

   typedef struct packed {
      logic [PW-1:0]  query;
      logic [PW-1:0]  cand;
      logic [LAW-1:0] idx;
      logic           last;
   } beat_t;

   logic           clk = 1'b0;
   logic           wrst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [AW-1:0]  in_leaf_index = '0;
   logic [PW-1:0]  in_patch = '0;
   logic           mem_ren;
   logic [LAW-1:0] mem_radr;
   logic [PW-1:0]  mem_rdata = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [PW-1:0]  out_query;
   logic [PW-1:0]  out_cand;
   logic [LAW-1:0] out_cand_idx;
   logic           out_last;
   logic           busy;

   int    checks = 0;
   int    failures = 0;
   int    adr0_cnt = 0;
   beat_t sb[$];
   beat_t got;
   beat_t exp_b;

   always #5 clk = ~clk;

   leaf_candidate_fetch #(
      .PATCH_WIDTH   (PW),
      .ADDRESS_WIDTH (AW),
      .LEAF_SIZE     (LS),
      .QDEPTH        (4)
   ) dut (
      .clk           (clk),
      .wrst_n        (wrst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_leaf_index (in_leaf_index),
      .in_patch      (in_patch),
      .mem_ren       (mem_ren),
      .mem_radr      (mem_radr),
      .mem_rdata     (mem_rdata),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_query     (out_query),
      .out_cand      (out_cand),
      .out_cand_idx  (out_cand_idx),
      .out_last      (out_last),
      .busy          (busy)
   );

   // Leaf SRAM: mem[a] = a, junk on the bus when not read
   always @(posedge clk) begin
      if (mem_ren) begin
         mem_rdata <= PW'(mem_radr);
         if (mem_radr == '0) adr0_cnt <= adr0_cnt + 1;
      end else begin
         mem_rdata <= {PW{1'b1}};
      end
   end

   task automatic push_query(input logic [AW-1:0] leaf, input logic [PW-1:0] patch);
      beat_t b;
      for (int k = 0; k < LS; k++) begin
         b.query = patch;
         b.idx   = {leaf, 3'(k)};
         b.cand  = PW'(b.idx);
         b.last  = (k == LS - 1);
         sb.push_back(b);
      end
   endtask

   task automatic test_reset();
      wrst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({in_ready, mem_ren, mem_radr, out_valid, busy} !== '0) begin
         failures++;
         $display("FAIL reset_ctrl got in_ready=%b mem_ren=%b mem_radr=%h out_valid=%b busy=%b exp all 0",
                  in_ready, mem_ren, mem_radr, out_valid, busy);
      end
      checks++;
      if ({out_query, out_cand, out_cand_idx, out_last} !== '0) begin
         failures++;
         $display("FAIL reset_data got %h exp 0", {out_query, out_cand, out_cand_idx, out_last});
      end
      wrst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL release_in_ready got %b exp 1", in_ready);
      end
   endtask

   task automatic test_single();
      logic [PW-1:0] p = PW'({$urandom(), $urandom()});
      int t_acc = -1;
      int t_first = -1;
      int n = 0;
      bit sent = 0;
      for (int c = 0; c < 60 && n < LS; c++) begin
         @(negedge clk);
         in_valid = !sent; in_leaf_index = 8'd59; in_patch = p; out_ready = 1'b1;
         #1;
         got = {out_query, out_cand, out_cand_idx, out_last};
         if (in_valid && in_ready) begin push_query(8'd59, p); sent = 1; t_acc = c; end
         if (out_valid && out_ready) begin
            if (t_first < 0) begin
               t_first = c;
               checks++;
               if (t_first - t_acc != 4) begin
                  failures++;
                  $display("FAIL single_latency got %0d exp 4", t_first - t_acc);
               end
            end
            checks++;
            if (c != t_first + n) begin
               failures++;
               $display("FAIL single_contig got cycle %0d exp %0d", c, t_first + n);
            end
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL single_beat got unexpected %h exp none", got);
            end else begin
               exp_b = sb.pop_front();
               if (got !== exp_b) begin
                  failures++;
                  $display("FAIL single_beat got %h exp %h", got, exp_b);
               end
            end
            n++;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (n != LS || sb.size() != 0) begin
         failures++;
         $display("FAIL single_count got %0d beats (%0d left) exp %0d", n, sb.size(), LS);
      end
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] leaves [3] = '{8'd59, 8'd60, 8'd22};
      logic [PW-1:0] pats [3];
      int oi = 0;
      int n = 0;
      int t_first = -1;
      for (int i = 0; i < 3; i++) pats[i] = PW'({$urandom(), $urandom()});
      for (int c = 0; c < 120 && n < 3 * LS; c++) begin
         @(negedge clk);
         in_valid = (oi < 3);
         if (oi < 3) begin in_leaf_index = leaves[oi]; in_patch = pats[oi]; end
         out_ready = 1'b1;
         #1;
         got = {out_query, out_cand, out_cand_idx, out_last};
         if (in_valid && in_ready) begin push_query(leaves[oi], pats[oi]); oi++; end
         if (out_valid && out_ready) begin
            if (t_first < 0) t_first = c;
            checks++;
            if (c != t_first + n) begin
               failures++;
               $display("FAIL b2b_contig got cycle %0d exp %0d", c, t_first + n);
            end
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL b2b_beat got unexpected %h exp none", got);
            end else begin
               exp_b = sb.pop_front();
               if (got !== exp_b) begin
                  failures++;
                  $display("FAIL b2b_beat got %h exp %h", got, exp_b);
               end
            end
            n++;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (n != 3 * LS) begin
         failures++;
         $display("FAIL b2b_count got %0d exp %0d", n, 3 * LS);
      end
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_idle got busy=%b out_valid=%b exp 0 0", busy, out_valid);
      end
   endtask

   task automatic test_full_fifo();
      int acc = 0;
      int n = 0;
      int bad_ready = 0;
      logic [AW-1:0] lf;
      logic [PW-1:0] pats [7];
      for (int i = 0; i < 7; i++) pats[i] = PW'({$urandom(), $urandom()});
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         lf = AW'(10 + 3 * acc);
         in_valid = (acc < 7); in_leaf_index = lf; in_patch = pats[acc % 7]; out_ready = 1'b0;
         #1;
         if (acc >= 5 && in_ready) bad_ready++;
         if (in_valid && in_ready) begin push_query(lf, pats[acc % 7]); acc++; end
      end
      checks++;
      if (acc != 5) begin
         failures++;
         $display("FAIL full_accepts got %0d exp 5", acc);
      end
      checks++;
      if (bad_ready != 0) begin
         failures++;
         $display("FAIL full_in_ready got %0d ready cycles exp 0", bad_ready);
      end
      for (int c = 0; c < 150 && n < 5 * LS; c++) begin
         @(negedge clk);
         in_valid = 1'b0; out_ready = 1'b1;
         #1;
         got = {out_query, out_cand, out_cand_idx, out_last};
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL full_beat got unexpected %h exp none", got);
            end else begin
               exp_b = sb.pop_front();
               if (got !== exp_b) begin
                  failures++;
                  $display("FAIL full_beat got %h exp %h", got, exp_b);
               end
            end
            n++;
         end
      end
      checks++;
      if (n != 5 * LS) begin
         failures++;
         $display("FAIL full_count got %0d exp %0d", n, 5 * LS);
      end
   endtask

   task automatic test_random_backpressure();
      logic [AW-1:0] leaves [5];
      logic [PW-1:0] pats [5];
      int oi = 0;
      int n = 0;
      bit hold = 0;
      beat_t held = '0;
      for (int i = 0; i < 5; i++) begin
         leaves[i] = AW'($urandom_range(1, 254));
         pats[i]   = PW'({$urandom(), $urandom()});
      end
      for (int c = 0; c < 500 && n < 5 * LS; c++) begin
         @(negedge clk);
         in_valid = (oi < 5);
         if (oi < 5) begin in_leaf_index = leaves[oi]; in_patch = pats[oi]; end
         out_ready = 1'($urandom_range(0, 1));
         #1;
         got = {out_query, out_cand, out_cand_idx, out_last};
         if (hold) begin
            checks++;
            if (out_valid !== 1'b1 || got !== held) begin
               failures++;
               $display("FAIL bp_stable got valid=%b %h exp valid=1 %h", out_valid, got, held);
            end
         end
         hold = out_valid && !out_ready;
         held = got;
         if (in_valid && in_ready) begin push_query(leaves[oi], pats[oi]); oi++; end
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL bp_beat got unexpected %h exp none", got);
            end else begin
               exp_b = sb.pop_front();
               if (got !== exp_b) begin
                  failures++;
                  $display("FAIL bp_beat got %h exp %h", got, exp_b);
               end
            end
            n++;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (n != 5 * LS || sb.size() != 0) begin
         failures++;
         $display("FAIL bp_count got %0d beats (%0d left) exp %0d", n, sb.size(), 5 * LS);
      end
   endtask

   task automatic test_reset_mid_leaf();
      logic [PW-1:0] p0 = PW'({$urandom(), $urandom()});
      logic [PW-1:0] p1 = PW'({$urandom(), $urandom()});
      int n = 0;
      bit sent = 0;
      for (int c = 0; c < 60 && n < 3; c++) begin
         @(negedge clk);
         in_valid = !sent; in_leaf_index = 8'd5; in_patch = p0; out_ready = 1'b1;
         #1;
         got = {out_query, out_cand, out_cand_idx, out_last};
         if (in_valid && in_ready) begin push_query(8'd5, p0); sent = 1; end
         if (out_valid && out_ready) begin
            checks++;
            exp_b = sb.pop_front();
            if (got !== exp_b) begin
               failures++;
               $display("FAIL rst_pre_beat got %h exp %h", got, exp_b);
            end
            n++;
         end
      end
      @(negedge clk);
      wrst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if ({in_ready, mem_ren, mem_radr, out_valid, busy, out_query, out_cand, out_cand_idx, out_last} !== '0) begin
         failures++;
         $display("FAIL rst_mid_outputs got in_ready=%b mem_ren=%b radr=%h valid=%b busy=%b data=%h exp all 0",
                  in_ready, mem_ren, mem_radr, out_valid, busy, {out_query, out_cand, out_cand_idx, out_last});
      end
      sb.delete();
      wrst_n = 1'b1;
      n = 0; sent = 0;
      for (int c = 0; c < 80 && (n < LS || c < 40); c++) begin
         @(negedge clk);
         in_valid = !sent; in_leaf_index = 8'd24; in_patch = p1; out_ready = 1'b1;
         #1;
         got = {out_query, out_cand, out_cand_idx, out_last};
         if (in_valid && in_ready) begin push_query(8'd24, p1); sent = 1; end
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL rst_post_beat got unexpected %h exp none", got);
            end else begin
               exp_b = sb.pop_front();
               if (got !== exp_b) begin
                  failures++;
                  $display("FAIL rst_post_beat got %h exp %h", got, exp_b);
               end
            end
            n++;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (n != LS) begin
         failures++;
         $display("FAIL rst_post_count got %0d exp %0d", n, LS);
      end
   endtask

   task automatic test_top_leaf();
      logic [PW-1:0] p = PW'({$urandom(), $urandom()});
      int a0 = adr0_cnt;
      int n = 0;
      bit sent = 0;
      for (int c = 0; c < 60 && n < LS; c++) begin
         @(negedge clk);
         in_valid = !sent; in_leaf_index = 8'd255; in_patch = p; out_ready = 1'b1;
         #1;
         got = {out_query, out_cand, out_cand_idx, out_last};
         if (in_valid && in_ready) begin push_query(8'd255, p); sent = 1; end
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL top_beat got unexpected %h exp none", got);
            end else begin
               exp_b = sb.pop_front();
               if (got !== exp_b) begin
                  failures++;
                  $display("FAIL top_beat got %h exp %h", got, exp_b);
               end
            end
            n++;
         end
      end
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (n != LS || adr0_cnt != a0) begin
         failures++;
         $display("FAIL top_leaf got %0d beats, %0d reads of addr 0 exp %0d beats, 0 reads", n, adr0_cnt - a0, LS);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_full_fifo();
      test_random_backpressure();
      test_reset_mid_leaf();
      test_top_leaf();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
